// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state type and index-width helper for the UART TX arbiter
package uart_arb_pkg;
  typedef enum logic {IDLE, LOCK} arb_state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: round-robin first-valid picker starting at rr_ptr; UART_ARB_PRIO0_EN gives client 0 priority
import uart_arb_pkg::*;
module uart_rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] pick,
  output logic            any
);
  always_comb begin
    pick = '0;
    // scan farthest-first so the nearest valid index from rr_ptr overwrites last
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[j]) pick = NREQ'(1) << j;
    end
`ifdef UART_ARB_PRIO0_EN
    if (req_valid[0]) pick = NREQ'(1);
`else
`endif
    any = |req_valid;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet-locked sharing of the UART TX FIFO write port with stall timeout
// Optional UART_ARB_PRIO0_EN: client 0 wins every arbitration in IDLE.
import uart_arb_pkg::*;
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int DBIT     = 8,
  parameter int LOCK_TMO = 255,
  parameter int TMO_BIT  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [DBIT-1:0]      w_data,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 tmo_err
);
  localparam int IW = idx_w(NREQ);
  arb_state_t state;
  logic [IW-1:0] g, rr_ptr, pick_idx, next_ptr;
  logic [TMO_BIT-1:0] tmo_cnt;
  logic [NREQ-1:0] pick;
  logic any, xfer;
  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid(req_valid),
    .rr_ptr(rr_ptr),
    .pick(pick),
    .any(any)
  );
  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) if (pick[k]) pick_idx = IW'(k);
  end
  assign xfer      = state == LOCK && req_valid[g] && !tx_full;
  assign req_ready = xfer ? grant : '0;
  assign wr_uart   = xfer;
  assign w_data    = xfer ? req_data[int'(g)*DBIT +: DBIT] : '0;
  assign busy      = state == LOCK;
  assign next_ptr  = g == IW'(NREQ - 1) ? '0 : g + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      g       <= '0;
      rr_ptr  <= '0;
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_err <= 1'b0;
      if (state == IDLE) begin
        if (any) begin
          state   <= LOCK;
          grant   <= pick;
          g       <= pick_idx;
          tmo_cnt <= '0;
        end
      end else if (xfer) begin
        tmo_cnt <= '0;
        if (req_last[g]) begin
          state  <= IDLE;
          grant  <= '0;
          rr_ptr <= next_ptr;
        end
      end else if (!req_valid[g] && !tx_full) begin
        // owner idle with room in the FIFO: count toward forced release
        if (tmo_cnt == TMO_BIT'(LOCK_TMO - 1)) begin
          state   <= IDLE;
          grant   <= '0;
          rr_ptr  <= next_ptr;
          tmo_err <= 1'b1;
        end else tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter (NREQ=4, LOCK_TMO=8)
module tb_uart_tx_arbiter;
  logic clk = 1'b0, reset = 1'b1, tx_full = 1'b0;
  logic [3:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [31:0] req_data = '0;
  logic wr_uart, busy, tmo_err;
  logic [7:0] w_data;
  int total = 0, bad = 0;
  int order [7] = '{2, 3, 0, 1, 2, 3, 0};
  uart_tx_arbiter #(.NREQ(4), .DBIT(8), .LOCK_TMO(8), .TMO_BIT(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .grant(grant), .busy(busy), .tmo_err(tmo_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic put(input int i, input logic [7:0] b);
    req_data[i*8 +: 8] = b;
  endtask
  initial begin
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_grant", grant, 0); chk("rst_busy", busy, 0);
    chk("rst_wr", wr_uart, 0); chk("rst_tmo", tmo_err, 0); chk("rst_ready", req_ready, 0);
    // client 1 packet A1 A2 A3
    req_valid = 4'b0010; put(1, 8'hA1);
    #1 chk("t1_idle_wr", wr_uart, 0);
    tick();
    chk("t1_grant", grant, 4'b0010); chk("t1_busy", busy, 1); chk("t1_ready", req_ready, 4'b0010);
    chk("t1_wr0", wr_uart, 1); chk("t1_d0", w_data, 8'hA1);
    tick(); put(1, 8'hA2);
    #1 chk("t1_wr1", wr_uart, 1); chk("t1_d1", w_data, 8'hA2);
    tick(); put(1, 8'hA3); req_last = 4'b0010;
    #1 chk("t1_wr2", wr_uart, 1); chk("t1_d2", w_data, 8'hA3);
    tick(); req_valid = '0; req_last = '0;
    #1 chk("t1_end_grant", grant, 0); chk("t1_end_busy", busy, 0);
    // all clients single-byte packets; rr_ptr=2 after client 1 released
    req_valid = 4'hF; req_last = 4'hF;
    for (int i = 0; i < 4; i++) put(i, 8'h10 + 8'(i));
    for (int n = 0; n < 7; n++) begin
      #1 chk("t2_idle_wr", wr_uart, 0); chk("t2_idle_busy", busy, 0);
      tick();
      chk("t2_grant", grant, 32'(1) << order[n]);
      chk("t2_data", w_data, 8'h10 + 8'(order[n])); chk("t2_wr", wr_uart, 1);
      tick();
    end
    // rr_ptr=1 now; clients 0 and 2 valid
    req_valid = 4'b0101; put(0, 8'h20); put(2, 8'h22);
    tick();
`ifdef UART_ARB_PRIO0_EN
    chk("t6_grant", grant, 4'b0001); chk("t6_data", w_data, 8'h20);
`else
    chk("t6_grant", grant, 4'b0100); chk("t6_data", w_data, 8'h22);
`endif
    tick(); req_valid = '0; req_last = '0;
    tick();
    // tx_full stall mid-packet on client 3
    req_valid = 4'b1000; put(3, 8'h31);
    tick();
    chk("t3_grant", grant, 4'b1000); chk("t3_d0", w_data, 8'h31);
    tick(); put(3, 8'h32); tx_full = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1 chk("t3_full_wr", wr_uart, 0); chk("t3_full_rdy", req_ready, 0); chk("t3_full_tmo", tmo_err, 0);
      tick();
    end
    tx_full = 1'b0;
    #1 chk("t3_grant_hold", grant, 4'b1000); chk("t3_d1", w_data, 8'h32); chk("t3_wr1", wr_uart, 1);
    tick(); put(3, 8'h33); req_last = 4'b1000;
    #1 chk("t3_d2", w_data, 8'h33);
    tick(); req_valid = '0; req_last = '0;
    tick();
    // timeout: client 0 stalls after one byte, client 2 waits
    req_valid = 4'b0001; put(0, 8'h41);
    tick();
    chk("t4_grant", grant, 4'b0001); chk("t4_d0", w_data, 8'h41);
    tick(); req_valid = 4'b0100; put(2, 8'h42); req_last = 4'b0100;
    for (int n = 1; n < 8; n++) begin
      tick();
      chk("t4_no_tmo", tmo_err, 0); chk("t4_hold", grant, 4'b0001);
    end
    tick();
    chk("t4_tmo", tmo_err, 1); chk("t4_rel_grant", grant, 0); chk("t4_rel_busy", busy, 0);
    tick();
    chk("t4_tmo_pulse", tmo_err, 0); chk("t4_next", grant, 4'b0100); chk("t4_next_d", w_data, 8'h42);
    tick(); req_valid = '0; req_last = '0;
    tick();
    // reset mid-packet after 2 of 5 bytes
    req_valid = 4'b0010; put(1, 8'hB1);
    tick();
    chk("t5_d0", w_data, 8'hB1);
    tick(); put(1, 8'hB2);
    #1 chk("t5_d1", w_data, 8'hB2);
    tick(); put(1, 8'hB3); reset = 1'b1;
    tick();
    chk("t5_grant", grant, 0); chk("t5_busy", busy, 0); chk("t5_wr", wr_uart, 0);
    reset = 1'b0;
    tick();
    chk("t5_regrant", grant, 4'b0010); chk("t5_d2", w_data, 8'hB3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
